// File: rtl/sprite_mux_arbiter_if.sv
// Sprite channel / multiplexer / downstream bus seen by the arbiter.
// master: the arbiter side; slave: requesters, mux and consumer side.
interface sprite_mux_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [15:0]      req;
  logic [15:0]      ack;
  logic [15:0]      mux_sel;
  logic [WIDTH-1:0] mux_b;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_id;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    input  req, mux_b, out_ready,
    output ack, mux_sel, out_data, out_id, out_valid, busy
  );

  modport slave (
    output req, mux_b, out_ready,
    input  ack, mux_sel, out_data, out_id, out_valid, busy
  );
endinterface

// File: rtl/sprite_mux_arbiter.sv
// Round-robin arbiter/sequencer for the 16-channel one-hot sprite mux.
// Grants one channel, selects it for one cycle, captures the word and
// holds it on a valid/ready output until the consumer takes it.
module sprite_mux_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  sprite_mux_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  logic [1:0]       state_q;
  logic [3:0]       last_q;
  logic [15:0]      sel_q;
  logic [15:0]      ack_q;
  logic [WIDTH-1:0] data_q;
  logic [3:0]       id_q;
  logic             valid_q;
  logic             busy_q;

  logic [15:0]      mreq;
  logic [3:0]       idx;
  logic [3:0]       win;
  logic [15:0]      win_oh;
  logic             found;

  // Round-robin search starting just after the last winner; the channel
  // being acknowledged this cycle is masked so its stale request is ignored.
  always_comb begin
    mreq  = bus.req & ~ack_q;
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int unsigned k = 1; k <= 16; k++) begin
      idx = last_q + 4'(k);
      if (!found && mreq[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_oh = 16'h0001 << win;
  end

  // Sequencer: IDLE -> CAPTURE (one cycle) -> HOLD until the word is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= 4'd15;
      sel_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            sel_q   <= win_oh;
            last_q  <= win;
            state_q <= ST_CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          data_q  <= bus.mux_b;
          id_q    <= last_q;
          valid_q <= 1'b1;
          ack_q   <= sel_q;
          sel_q   <= '0;
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
            if (found) begin
              sel_q   <= win_oh;
              last_q  <= win;
              state_q <= ST_CAPTURE;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_sel   = sel_q;
  assign bus.ack       = ack_q;
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sprite_mux_arbiter.sv
// Bench for sprite_mux_arbiter: directed scenarios plus randomized
// requesters, all checked every cycle against a transaction-level model.
module tb_sprite_mux_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sprite_mux_arbiter_if #(.WIDTH(32)) bus ();
  sprite_mux_arbiter #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] chan_data [16];
  logic [15:0] after_ack;
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Multiplexer model: combinational OR of selected channels.
  always_comb begin
    bus.mux_b = '0;
    for (int i = 0; i < 16; i++)
      if (bus.mux_sel[i]) bus.mux_b = bus.mux_b | chan_data[i];
  end

  typedef struct {
    int          sel;    // channel on the mux this cycle, -1 if none
    logic        valid;  // a captured word is waiting downstream
    logic [15:0] ack;
    int          last;
    logic [31:0] data;
    logic [3:0]  id;
  } mstate_t;

  mstate_t m;

  function automatic logic [15:0] onehot(input int ch);
    if (ch < 0) return 16'h0000;
    return 16'h0001 << ch;
  endfunction

  function automatic int oh2idx(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Winner = requesting channel at smallest circular distance past 'last'.
  function automatic int rr_pick(input logic [15:0] r, input int last);
    int best = -1;
    int bestd = 99;
    for (int i = 0; i < 16; i++) begin
      int d = (i - last - 1 + 32) % 16;
      if (r[i] && d < bestd) begin
        bestd = d;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic rst,
                                         input logic [15:0] r, input logic rdy);
    mstate_t n;
    int w;
    n = s;
    if (rst) begin
      n.sel = -1; n.valid = 1'b0; n.ack = '0; n.last = 15; n.data = '0; n.id = '0;
    end else begin
      n.ack = '0;
      if (s.sel >= 0) begin
        n.data  = chan_data[s.sel];
        n.id    = 4'(s.sel);
        n.valid = 1'b1;
        n.ack   = onehot(s.sel);
        n.sel   = -1;
      end else if (!s.valid || rdy) begin
        n.valid = 1'b0;
        w = rr_pick(r & ~s.ack, s.last);
        if (w >= 0) begin
          n.sel  = w;
          n.last = w;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, reset, bus.req, bus.out_ready);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_mux_sel",   bus.mux_sel,   onehot(m.sel));
      check("m_ack",       bus.ack,       m.ack);
      check("m_out_valid", bus.out_valid, m.valid);
      check("m_out_data",  bus.out_data,  m.data);
      check("m_out_id",    bus.out_id,    m.id);
      check("m_busy",      bus.busy,      (m.sel >= 0) || m.valid);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sel"},   bus.mux_sel,   0);
    check({tag, "_ack"},   bus.ack,       0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_busy"},  bus.busy,      0);
    check({tag, "_data"},  bus.out_data,  0);
    check({tag, "_id"},    bus.out_id,    0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (bus.busy || bus.out_valid); i++) step();
    check("drain_busy", bus.busy, 0);
  endtask

  task automatic rand_requesters();
    logic [15:0] r;
    r = bus.req;
    for (int i = 0; i < 16; i++) begin
      if (after_ack[i]) begin
        if ($urandom_range(0, 1) == 1) begin
          r[i] = 1'b1;
          chan_data[i] = $urandom;
        end else begin
          r[i] = 1'b0;
        end
      end else if (!r[i] && $urandom_range(0, 7) == 0) begin
        r[i] = 1'b1;
        chan_data[i] = $urandom;
      end
    end
    after_ack = bus.ack;
    bus.req = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int ids [17];
    int cyc [17];
    int got;
    int bad;
    int acks;
    logic [31:0] d_hold;
    logic [3:0]  id_hold;

    for (int i = 0; i < 16; i++) chan_data[i] = $urandom;
    after_ack     = '0;
    bus.req       = 16'hFFFF;
    bus.out_ready = 1'b1;

    // Reset with all channels requesting.
    step();
    chk_en = 1'b1;
    check_zero("rst1");
    step();
    check_zero("rst2");
    reset = 1'b0;
    step();
    check("first_grant", bus.mux_sel, 16'h0001);
    reset = 1'b1;
    bus.req = 16'h0000;
    step();
    reset = 1'b0;
    step();

    // Single request on channel 5.
    chan_data[5] = 32'hDEADBEEF;
    bus.req = 16'h0020;
    step();
    check("single_sel", bus.mux_sel, 16'h0020);
    step();
    check("single_data",  bus.out_data,  32'hDEADBEEF);
    check("single_id",    bus.out_id,    5);
    check("single_ack",   bus.ack,       16'h0020);
    check("single_valid", bus.out_valid, 1);
    check("single_sel0",  bus.mux_sel,   16'h0000);
    step();
    bus.req = 16'h0000;
    check("single_idle_valid", bus.out_valid, 0);
    check("single_idle_busy",  bus.busy,      0);
    check("single_idle_sel",   bus.mux_sel,   0);

    // Round-robin fairness with every channel requesting.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) chan_data[i] = $urandom;
    bus.req = 16'hFFFF;
    got = 0;
    for (int c = 0; c < 60 && got < 17; c++) begin
      step();
      if (bus.ack != 0) begin
        ids[got] = oh2idx(bus.ack);
        cyc[got] = c;
        got++;
        if (got == 17) bus.req = 16'h0000;
      end
    end
    check("rr_count", got, 17);
    for (int k = 0; k < got; k++) check("rr_order", ids[k], k % 16);
    bad = 0;
    for (int k = 1; k < got; k++) if (cyc[k] - cyc[k-1] != 2) bad++;
    check("rr_spacing", bad, 0);
    drain();

    // Backpressure on channel 8.
    bus.out_ready = 1'b0;
    chan_data[8] = $urandom;
    bus.req = 16'h0100;
    step();
    check("bp_sel", bus.mux_sel, 16'h0100);
    step();
    check("bp_valid", bus.out_valid, 1);
    check("bp_ack",   bus.ack,       16'h0100);
    check("bp_data",  bus.out_data,  chan_data[8]);
    d_hold  = bus.out_data;
    id_hold = bus.out_id;
    acks = 1;
    bad  = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) bus.req = 16'h0000;
      if (bus.ack != 0) acks++;
      if (bus.out_data !== d_hold || bus.out_id !== id_hold ||
          bus.mux_sel !== 16'h0000 || bus.out_valid !== 1'b1) bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_acks",   acks, 1);
    bus.out_ready = 1'b1;
    step();
    check("bp_xfer", bus.out_valid, 0);

    // Sparse wrap between channels 15 and 0.
    bus.req = 16'h8000;
    step();
    step();
    check("wrap_ack15", bus.ack, 16'h8000);
    bus.req = 16'h8001;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      step();
      if (bus.ack != 0) begin
        ids[got] = oh2idx(bus.ack);
        got++;
        if (got == 3) bus.req = 16'h0000;
      end
    end
    check("wrap_count", got, 3);
    check("wrap_0", ids[0], 0);
    check("wrap_1", ids[1], 15);
    check("wrap_2", ids[2], 0);
    drain();

    // Reset while channel 3 is being captured.
    chan_data[3] = $urandom;
    bus.req = 16'h0008;
    step();
    check("rm_sel", bus.mux_sel, 16'h0008);
    reset = 1'b1;
    step();
    check_zero("rm");
    reset = 1'b0;
    step();
    check("rm_regrant", bus.mux_sel, 16'h0008);
    step();
    check("rm_ack", bus.ack, 16'h0008);
    step();
    bus.req = 16'h0000;
    drain();

    // Randomized traffic, backpressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 399) == 0);
      rand_requesters();
      step();
    end
    reset = 1'b0;
    bus.req = 16'h0000;
    bus.out_ready = 1'b1;
    step();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
